reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Register-hazard interlock controller for the 5-stage MIPS pipeline; sits beside the ID stage.
- Tracks in-flight writes to each GPR from issue (ID→EX handshake) to retire (WB write to regfile).
- Produces the ID-stage stall (drives ds_ready_go low) while any source operand, or a saturated destination, has a pending write.
- No forwarding: a source may be read only once its pending count is zero.

Parameters:
- NREG, 32, number of architectural registers tracked; index 0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max pending per register = 2^CNT_W-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ds_valid  in  1  ID stage holds a valid instruction
- ds_rs  in  5  source register 1 address
- ds_rs_used  in  1  instruction reads rs
- ds_rt  in  5  source register 2 address
- ds_rt_used  in  1  instruction reads rt
- ds_gr_we  in  1  instruction writes a GPR
- ds_dest  in  5  destination register
- ds_issue  in  1  ID→EX transfer this cycle (ds_to_es_valid & es_allowin)
- ws_we  in  1  WB writes regfile this cycle
- ws_dest  in  5  WB destination register
- flush  in  1  clear all pending state (pipeline drained/killed)
- ds_stall  out  1  ID must not go; ds_ready_go = ~ds_stall
- rs_pending  out  1  rs has a pending write
- rt_pending  out  1  rt has a pending write
- inflight  out  4  total pending writes, all registers
- sb_idle  out  1  inflight == 0
- sb_err  out  1  sticky: underflow (retire with zero count)

Behaviour:
- State: cnt[1..NREG-1], CNT_W bits each; tot counter (4 bits); sticky err.
- Reset/flush (synchronous): all cnt=0, tot=0. Reset clears err; flush does not. Outputs after reset: ds_stall=0, rs_pending=0, rt_pending=0, inflight=0, sb_idle=1, sb_err=0. Reset has priority over all else; flush has priority over issue/retire in the same cycle.
- Combinational outputs from registered state only; no same-cycle retire bypass, because the regfile write lands at the edge.
  - rs_pending = ds_rs_used & ds_rs!=0 & cnt[ds_rs]!=0; rt_pending likewise.
  - dest_full = ds_gr_we & ds_dest!=0 & cnt[ds_dest]==max.
  - ds_stall = ds_valid & (rs_pending | rt_pending | dest_full). When ds_valid=0, ds_stall=0.
- Issue inc: ds_issue & ds_gr_we & ds_dest!=0. Retire dec: ws_we & ws_dest!=0.
- ds_issue asserted while ds_stall=1 is a protocol violation; the increment is ignored.
- Per-register update at posedge:
  - inc only: +1.
  - dec only: −1; if already 0, stays 0 and err←1.
  - Both on the same register: unchanged, net 0. If that count is 0, no error.
  - Different registers: each updated independently.
- tot tracks the sum: +1 on inc, −1 on dec, net 0 on both. Underflowing decs do not decrement tot. Saturates at 15, which is unreachable in a 5-stage pipe. inflight=tot; sb_idle=(tot==0).
- Register 0: never counted, never stalls; writes to r0 are ignored.
- Latency: issue at edge N makes a dependent stall visible in cycle N+1. Retire at edge M releases the stall in cycle M+1, when the regfile already holds the new value.
- Implementation: ~150–250 lines; a counter array with a generate loop, a total counter and output logic.

Test Plan:
- Reset: assert reset 2 cycles with ds_valid=1, ds_rs=5 → ds_stall=0, inflight=0, sb_idle=1, sb_err=0.
- RAW: issue addu r3 (ds_gr_we=1, ds_dest=3). Next cycle ds_rs=3, rs_used=1 → ds_stall=1, rs_pending=1. After ws_we=1, ws_dest=3 → ds_stall=0 the following cycle.
- Simultaneous: cnt[7]=1; same cycle issue dest=7 and retire dest=7 → cnt[7]=1, inflight unchanged, no err.
- Saturation: issue dest=9 three times with no retire → cnt=3. Fourth instruction with dest=9 → ds_stall=1 (dest_full). One retire → stall drops next cycle.
- r0 and unused sources: issue dest=0, then ds_rs=0, and ds_rt=4 with rt_used=0 while cnt[4]=1 → ds_stall=0, inflight unchanged.
- Underflow/flush: retire dest=12 at cnt 0 → sb_err=1, inflight=0. Flush with 2 pending → inflight=0, sb_idle=1, sb_err stays 1 until reset.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register-hazard interlock: per-GPR pending-write counters from issue to retire,
// producing the ID-stage stall while a source or a saturated destination is busy.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ds_valid,
    input  logic [4:0] ds_rs,
    input  logic       ds_rs_used,
    input  logic [4:0] ds_rt,
    input  logic       ds_rt_used,
    input  logic       ds_gr_we,
    input  logic [4:0] ds_dest,
    input  logic       ds_issue,
    input  logic       ws_we,
    input  logic [4:0] ws_dest,
    input  logic       flush,
    output logic       ds_stall,
    output logic       rs_pending,
    output logic       rt_pending,
    output logic [3:0] inflight,
    output logic       sb_idle,
    output logic       sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  uflow;
    logic [3:0]       tot;
    logic             err;
    logic             dest_full;
    logic             inc_en;
    logic             dec_en;
    logic             dec_tot;

    // r0 is hardwired idle so it can never stall or be counted
    assign cnt[0]   = '0;
    assign uflow[0] = 1'b0;

    generate
        for (genvar i = 1; i < NREG; i++) begin : g_cnt
            localparam logic [4:0] IDX = 5'(i);
            logic [CNT_W-1:0] c;
            logic             inc_i;
            logic             dec_i;

            assign inc_i    = inc_en & (ds_dest == IDX);
            assign dec_i    = dec_en & (ws_dest == IDX);
            assign uflow[i] = dec_i & ~inc_i & (c == '0);
            assign cnt[i]   = c;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    c <= '0;
                end else if (inc_i && !dec_i) begin
                    c <= c + CNT_ONE;
                end else if (dec_i && !inc_i && c != '0) begin
                    c <= c - CNT_ONE;
                end
            end
        end
    endgenerate

    // Stall is from registered counts only: a retire this cycle releases next cycle
    always_comb begin
        rs_pending = ds_rs_used & (ds_rs != 5'd0) & (cnt[ds_rs] != '0);
        rt_pending = ds_rt_used & (ds_rt != 5'd0) & (cnt[ds_rt] != '0);
        dest_full  = ds_gr_we & (ds_dest != 5'd0) & (cnt[ds_dest] == CNT_MAX);
        ds_stall   = ds_valid & (rs_pending | rt_pending | dest_full);
    end

    // An issue attempted during a stall is ignored rather than corrupting counts
    assign inc_en  = ds_issue & ds_gr_we & (ds_dest != 5'd0) & ~ds_stall & ~dest_full;
    assign dec_en  = ws_we & (ws_dest != 5'd0);
    assign dec_tot = dec_en & ~(|uflow);

    always_ff @(posedge clk) begin
        if (reset) begin
            tot <= 4'd0;
            err <= 1'b0;
        end else if (flush) begin
            tot <= 4'd0;
        end else begin
            if (|uflow) begin
                err <= 1'b1;
            end
            case ({inc_en, dec_tot})
                2'b10:   if (tot != 4'd15) tot <= tot + 4'd1;
                2'b01:   if (tot != 4'd0)  tot <= tot - 4'd1;
                default: tot <= tot;
            endcase
        end
    end

    assign inflight = tot;
    assign sb_idle  = (tot == 4'd0);
    assign sb_err   = err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed plus constrained-random checks of reg_scoreboard against a behavioural
// model, with expectations queued at stimulus time and popped at the sample point.
module tb_reg_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       ds_valid;
    logic [4:0] ds_rs;
    logic       ds_rs_used;
    logic [4:0] ds_rt;
    logic       ds_rt_used;
    logic       ds_gr_we;
    logic [4:0] ds_dest;
    logic       ds_issue;
    logic       ws_we;
    logic [4:0] ws_dest;
    logic       flush;
    logic       ds_stall;
    logic       rs_pending;
    logic       rt_pending;
    logic [3:0] inflight;
    logic       sb_idle;
    logic       sb_err;

    reg_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .ds_valid   (ds_valid),
        .ds_rs      (ds_rs),
        .ds_rs_used (ds_rs_used),
        .ds_rt      (ds_rt),
        .ds_rt_used (ds_rt_used),
        .ds_gr_we   (ds_gr_we),
        .ds_dest    (ds_dest),
        .ds_issue   (ds_issue),
        .ws_we      (ws_we),
        .ws_dest    (ws_dest),
        .flush      (flush),
        .ds_stall   (ds_stall),
        .rs_pending (rs_pending),
        .rt_pending (rt_pending),
        .inflight   (inflight),
        .sb_idle    (sb_idle),
        .sb_err     (sb_err)
    );

    always #5 clk = ~clk;

    localparam int S_STALL = 0, S_RSP = 1, S_RTP = 2, S_INF = 3, S_IDLE = 4, S_ERR = 5;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    int mc[32];
    int mtot = 0;
    bit merr = 1'b0;

    function automatic logic [3:0] observed(input int sel);
        case (sel)
            S_STALL: return {3'b0, ds_stall};
            S_RSP:   return {3'b0, rs_pending};
            S_RTP:   return {3'b0, rt_pending};
            S_INF:   return inflight;
            S_IDLE:  return {3'b0, sb_idle};
            default: return {3'b0, sb_err};
        endcase
    endfunction

    function automatic bit m_rp();
        return ds_rs_used && ds_rs != 0 && mc[ds_rs] > 0;
    endfunction

    function automatic bit m_tp();
        return ds_rt_used && ds_rt != 0 && mc[ds_rt] > 0;
    endfunction

    function automatic bit m_stall();
        bit full;
        full = ds_gr_we && ds_dest != 0 && mc[ds_dest] == 3;
        return ds_valid && (m_rp() || m_tp() || full);
    endfunction

    task automatic expect_sig(input string tag, input int sel, input logic [3:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic check_all();
        exp_t       e;
        logic [3:0] obs;
        while (sbq.size() > 0) begin
            e   = sbq.pop_front();
            obs = observed(e.sel);
            n_checks++;
            assert (obs === e.val) else begin
                n_fails++;
                $error("FAIL %s observed=%0d expected=%0d at %0t", e.tag, obs, e.val, $time);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic rsu,
                         input logic [4:0] rt, input logic rtu, input logic we,
                         input logic [4:0] d, input logic iss, input logic wwe,
                         input logic [4:0] wd, input logic fl);
        ds_valid   = v;
        ds_rs      = rs;
        ds_rs_used = rsu;
        ds_rt      = rt;
        ds_rt_used = rtu;
        ds_gr_we   = we;
        ds_dest    = d;
        ds_issue   = iss;
        ws_we      = wwe;
        ws_dest    = wd;
        flush      = fl;
    endtask

    // Compare this cycle's outputs, then advance the model across the next edge.
    task automatic step();
        bit st, inc, dec;
        #1;
        st = m_stall();
        expect_sig("m_stall", S_STALL, {3'b0, st});
        expect_sig("m_rs_pending", S_RSP, {3'b0, m_rp()});
        expect_sig("m_rt_pending", S_RTP, {3'b0, m_tp()});
        expect_sig("m_inflight", S_INF, 4'(mtot));
        expect_sig("m_idle", S_IDLE, {3'b0, mtot == 0});
        expect_sig("m_err", S_ERR, {3'b0, merr});
        check_all();
        if (reset) begin
            foreach (mc[i]) mc[i] = 0;
            mtot = 0;
            merr = 1'b0;
        end else if (flush) begin
            foreach (mc[i]) mc[i] = 0;
            mtot = 0;
        end else begin
            inc = ds_issue && ds_gr_we && ds_dest != 0 && !st && mc[ds_dest] < 3;
            dec = ws_we && ws_dest != 0;
            if (!(inc && dec && ds_dest == ws_dest)) begin
                if (inc) begin
                    mc[ds_dest]++;
                    if (mtot < 15) mtot++;
                end
                if (dec) begin
                    if (mc[ws_dest] == 0) begin
                        merr = 1'b1;
                    end else begin
                        mc[ws_dest]--;
                        if (mtot > 0) mtot--;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        foreach (mc[i]) mc[i] = 0;
        reset = 1'b1;
        drive(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_sig("reset_stall", S_STALL, 4'd0);
        expect_sig("reset_inflight", S_INF, 4'd0);
        expect_sig("reset_idle", S_IDLE, 4'd1);
        expect_sig("reset_err", S_ERR, 4'd0);
        step();
        reset = 1'b0;

        // RAW on r3
        drive(1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0);
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_sig("raw_stall", S_STALL, 4'd1);
        expect_sig("raw_rs_pending", S_RSP, 4'd1);
        expect_sig("raw_inflight", S_INF, 4'd1);
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 1, 3, 0);
        expect_sig("raw_no_bypass", S_STALL, 4'd1);
        step();
        drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_sig("raw_released", S_STALL, 4'd0);
        expect_sig("raw_idle", S_IDLE, 4'd1);
        step();

        // Simultaneous issue and retire on r7
        drive(1, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 7, 1, 1, 7, 0);
        expect_sig("simul_before", S_INF, 4'd1);
        step();
        drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_sig("simul_inflight", S_INF, 4'd1);
        expect_sig("simul_pending", S_RSP, 4'd1);
        expect_sig("simul_err", S_ERR, 4'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        step();

        // Saturation on r9
        repeat (3) begin
            drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
            step();
        end
        drive(1, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        expect_sig("sat_dest_full", S_STALL, 4'd1);
        expect_sig("sat_inflight", S_INF, 4'd3);
        step();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 1, 9, 0);
        expect_sig("sat_ignored_issue", S_INF, 4'd3);
        expect_sig("sat_still_full", S_STALL, 4'd1);
        step();
        drive(1, 0, 0, 0, 0, 1, 9, 0, 1, 9, 0);
        expect_sig("sat_released", S_STALL, 4'd0);
        expect_sig("sat_after_retire", S_INF, 4'd2);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step();

        // r0 and unused sources
        drive(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 0);
        expect_sig("r0_not_counted", S_INF, 4'd0);
        step();
        drive(1, 0, 1, 4, 0, 1, 0, 0, 0, 0, 0);
        expect_sig("r0_unused_stall", S_STALL, 4'd0);
        expect_sig("r0_unused_inflight", S_INF, 4'd1);
        step();
        drive(1, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0);
        expect_sig("rt_used_pending", S_RTP, 4'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0);
        step();

        // Underflow then flush
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
        expect_sig("uflow_err", S_ERR, 4'd1);
        expect_sig("uflow_inflight", S_INF, 4'd0);
        step();
        drive(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 1, 5, 1, 1, 1, 1);
        expect_sig("pre_flush", S_INF, 4'd2);
        step();
        drive(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_sig("flush_inflight", S_INF, 4'd0);
        expect_sig("flush_idle", S_IDLE, 4'd1);
        expect_sig("flush_err_sticky", S_ERR, 4'd1);
        expect_sig("flush_no_stall", S_STALL, 4'd0);
        step();

        // Constrained-random against the model
        for (int k = 0; k < 400; k++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                  5'($urandom_range(0, 7)), 1'b0, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)), $urandom_range(0, 49) == 0);
            ds_issue = ds_valid && !m_stall() && ($urandom_range(0, 3) != 0);
            step();
        end

        // Reset clears the sticky error
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        expect_sig("final_err_cleared", S_ERR, 4'd0);
        expect_sig("final_idle", S_IDLE, 4'd1);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
